// File: rtl/hk_frame_scheduler.sv
// Housekeeping telemetry frame scheduler: periodic/commanded triggers, atomic
// bank snapshot, SYNC + data + checksum stream over valid/ready.
module hk_frame_scheduler #(
   parameter int unsigned       NUM_WORDS  = 10,
   parameter int unsigned       WORD_W     = 10,
   parameter int unsigned       PERIOD_CYC = 50_000_000,
   parameter logic [WORD_W-1:0] SYNC_WORD  = 10'h3A5
) (
   input  logic                        clk50,
   input  logic                        rst,
   input  logic                        enable,
   input  logic                        cmd_req,
   input  logic [NUM_WORDS*WORD_W-1:0] words_in,
   output logic                        snap,
   output logic [WORD_W-1:0]           out_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic                        out_last,
   output logic                        busy,
   output logic [15:0]                 frame_cnt,
   output logic [7:0]                  miss_cnt
);

   localparam int unsigned IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam int unsigned TMR_W = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
   localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(PERIOD_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SNAP,
      S_SYNC,
      S_DATA,
      S_CKSUM
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [WORD_W-1:0]  csum_q, csum_d;
   logic [WORD_W-1:0]  shadow_q [NUM_WORDS];
   logic [TMR_W-1:0]   timer_q;
   logic               tick;
   logic               trigger;
   logic               accept;
   logic               load_shadow;
   logic               frame_done;
   logic               nx_snap;
   logic               nx_valid;
   logic               nx_last;
   logic [WORD_W-1:0]  nx_data;

   assign tick    = enable && (timer_q == TMR_MAX);
   assign trigger = tick || cmd_req;
   assign accept  = out_valid && out_ready;

   always_ff @(posedge clk50) begin
      if (rst || !enable || tick) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_q + TMR_W'(1);
      end
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      csum_d      = csum_q;
      load_shadow = 1'b0;
      frame_done  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (trigger) state_d = S_SNAP;
         end
         S_SNAP: begin
            load_shadow = 1'b1;
            idx_d       = '0;
            csum_d      = '0;
            state_d     = S_SYNC;
         end
         S_SYNC: begin
            if (accept) state_d = S_DATA;
         end
         S_DATA: begin
            if (accept) begin
               csum_d = csum_q + shadow_q[idx_q];
               if (idx_q == LAST_IDX) begin
                  state_d = S_CKSUM;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         S_CKSUM: begin
            if (accept) begin
               frame_done = 1'b1;
               state_d    = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are registered from the next state, so they line up with the state they describe.
   always_comb begin
      nx_snap  = (state_d == S_SNAP);
      nx_valid = (state_d == S_SYNC) || (state_d == S_DATA) || (state_d == S_CKSUM);
      nx_last  = (state_d == S_CKSUM);
      nx_data  = '0;
      case (state_d)
         S_SYNC:  nx_data = SYNC_WORD;
         S_DATA:  nx_data = shadow_q[idx_d];
         S_CKSUM: nx_data = csum_d;
         default: nx_data = '0;
      endcase
   end

   always_ff @(posedge clk50) begin
      if (rst) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         csum_q    <= '0;
         snap      <= 1'b0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= '0;
         busy      <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         csum_q    <= csum_d;
         snap      <= nx_snap;
         out_valid <= nx_valid;
         out_last  <= nx_last;
         out_data  <= nx_data;
         busy      <= (state_d != S_IDLE);
      end
   end

   always_ff @(posedge clk50) begin
      if (rst) begin
         for (int unsigned k = 0; k < NUM_WORDS; k++) shadow_q[k] <= '0;
      end else if (load_shadow) begin
         for (int unsigned k = 0; k < NUM_WORDS; k++) shadow_q[k] <= words_in[k*WORD_W +: WORD_W];
      end
   end

   always_ff @(posedge clk50) begin
      if (rst) begin
         frame_cnt <= '0;
         miss_cnt  <= '0;
      end else begin
         if (frame_done) frame_cnt <= frame_cnt + 16'd1;
         if (trigger && (state_q != S_IDLE) && (miss_cnt != '1)) miss_cnt <= miss_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_hk_frame_scheduler.sv
// Self-checking bench for hk_frame_scheduler: directed scenarios plus random
// traffic compared cycle by cycle against a transaction-level frame model.
module tb_hk_frame_scheduler;

   localparam int unsigned NW = 10;
   localparam int unsigned WW = 10;
   localparam int unsigned P  = 20;
   localparam logic [WW-1:0] SYNC = 10'h3A5;

   logic              clk50 = 1'b0;
   logic              rst;
   logic              enable;
   logic              cmd_req;
   logic [NW*WW-1:0]  words_in;
   logic              snap;
   logic [WW-1:0]     out_data;
   logic              out_valid;
   logic              out_ready;
   logic              out_last;
   logic              busy;
   logic [15:0]       frame_cnt;
   logic [7:0]        miss_cnt;

   hk_frame_scheduler #(
      .NUM_WORDS  (NW),
      .WORD_W     (WW),
      .PERIOD_CYC (P),
      .SYNC_WORD  (SYNC)
   ) dut (
      .clk50     (clk50),
      .rst       (rst),
      .enable    (enable),
      .cmd_req   (cmd_req),
      .words_in  (words_in),
      .snap      (snap),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .busy      (busy),
      .frame_cnt (frame_cnt),
      .miss_cnt  (miss_cnt)
   );

   always #10 clk50 = ~clk50;

   int errors = 0;
   int checks = 0;

   // Model: phase 0 idle, 1 snapshot cycle, 2 streaming word m_pos (0=SYNC, NW+1=checksum).
   int            m_phase;
   int            m_pos;
   int            m_timer;
   int            m_miss;
   logic [15:0]   m_frames;
   logic [WW-1:0] m_shadow [NW];
   int            snap_seen;
   logic [WW-1:0] acc_q [$];
   logic [WW-1:0] bank [NW];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [WW-1:0] model_word(input int pos);
      int sum;
      if (pos == 0) return SYNC;
      if (pos <= NW) return m_shadow[pos-1];
      sum = 0;
      for (int k = 0; k < NW; k++) sum += int'(m_shadow[k]);
      return WW'(sum % 1024);
   endfunction

   task automatic check_outputs();
      logic exp_valid;
      exp_valid = (m_phase == 2);
      chk("busy", busy, m_phase != 0);
      chk("snap", snap, m_phase == 1);
      chk("out_valid", out_valid, exp_valid);
      chk("out_last", out_last, exp_valid && (m_pos == NW + 1));
      if (exp_valid) chk("out_data", out_data, model_word(m_pos));
      chk("frame_cnt", frame_cnt, m_frames);
      chk("miss_cnt", miss_cnt, m_miss);
      if (snap === 1'b1) snap_seen++;
   endtask

   task automatic apply_bank();
      for (int k = 0; k < NW; k++) words_in[k*WW +: WW] = bank[k];
   endtask

   task automatic step(input logic r, input logic en, input logic cmd, input logic rdy);
      logic             trig;
      logic [NW*WW-1:0] cur_words;
      check_outputs();
      rst       = r;
      enable    = en;
      cmd_req   = cmd;
      out_ready = rdy;
      if (!r && out_valid && rdy) acc_q.push_back(out_data);
      trig      = (en && (m_timer == P - 1)) || cmd;
      cur_words = words_in;
      @(posedge clk50);
      if (r) begin
         m_phase  = 0;
         m_pos    = 0;
         m_timer  = 0;
         m_miss   = 0;
         m_frames = '0;
         for (int k = 0; k < NW; k++) m_shadow[k] = '0;
      end else begin
         m_timer = en ? ((m_timer == P - 1) ? 0 : m_timer + 1) : 0;
         if (m_phase == 0) begin
            if (trig) m_phase = 1;
         end else begin
            if (trig && m_miss < 255) m_miss++;
            if (m_phase == 1) begin
               for (int k = 0; k < NW; k++) m_shadow[k] = cur_words[k*WW +: WW];
               m_phase = 2;
               m_pos   = 0;
            end else if (rdy) begin
               if (m_pos == NW + 1) begin
                  m_phase  = 0;
                  m_frames = m_frames + 16'd1;
               end else begin
                  m_pos++;
               end
            end
         end
      end
      @(negedge clk50);
   endtask

   initial begin
      int sum;
      rst       = 1'b1;
      enable    = 1'b0;
      cmd_req   = 1'b0;
      out_ready = 1'b0;
      words_in  = '0;
      m_phase   = 0;
      m_pos     = 0;
      m_timer   = 0;
      m_miss    = 0;
      m_frames  = '0;
      snap_seen = 0;
      for (int k = 0; k < NW; k++) m_shadow[k] = '0;
      repeat (2) @(posedge clk50);
      @(negedge clk50);

      // Reset state
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_data", out_data, '0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_snap", snap, 1'b0);
      chk("rst_frames", frame_cnt, '0);
      chk("rst_miss", miss_cnt, '0);

      // 1: single commanded frame, bank k -> k+1
      for (int k = 0; k < NW; k++) bank[k] = WW'(k + 1);
      apply_bank();
      acc_q.delete();
      snap_seen = 0;
      step(1'b0, 1'b0, 1'b1, 1'b1);
      repeat (15) step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("t1_len", acc_q.size(), 12);
      if (acc_q.size() == 12) begin
         chk("t1_sync", acc_q[0], 10'h3A5);
         for (int k = 1; k <= NW; k++) chk("t1_word", acc_q[k], k);
         chk("t1_csum", acc_q[11], 10'h037);
      end
      chk("t1_frames", frame_cnt, 16'd1);
      chk("t1_snaps", snap_seen, 1);

      // 2: periodic timer, 100 enabled cycles -> 5 frames
      repeat (100) step(1'b0, 1'b1, 1'b0, 1'b1);
      repeat (20) step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("t2_frames", frame_cnt, 16'd6);

      // 3: ready toggling, all-ones bank
      for (int k = 0; k < NW; k++) bank[k] = 10'h3FF;
      apply_bank();
      acc_q.delete();
      step(1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 1'b0, (i % 2) == 0);
      chk("t3_len", acc_q.size(), 12);
      if (acc_q.size() == 12) chk("t3_csum", acc_q[11], 10'h3F6);
      chk("t3_frames", frame_cnt, 16'd7);

      // 4: mid-frame request, then tick and request together in IDLE
      repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b1);
      repeat (5) step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1, 1'b1);
      repeat (12) step(1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 20; i++) step(1'b0, 1'b1, i == 19, 1'b1);
      repeat (16) step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("t4_miss", miss_cnt, 8'd1);
      chk("t4_frames", frame_cnt, 16'd2);

      // 5: miss counter saturation while stalled
      repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 600; i++) step(1'b0, 1'b0, (i % 2) == 0, 1'b0);
      chk("t5_miss", miss_cnt, 8'd255);
      repeat (20) step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("t5_miss_held", miss_cnt, 8'd255);
      chk("t5_frames", frame_cnt, 16'd1);

      // 6: reset during DATA word 4, then a clean frame
      repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < NW; k++) bank[k] = WW'($urandom);
      apply_bank();
      step(1'b0, 1'b0, 1'b1, 1'b1);
      repeat (6) step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("t6_word4", out_data, bank[4]);
      step(1'b1, 1'b0, 1'b0, 1'b1);
      chk("t6_valid", out_valid, 1'b0);
      chk("t6_last", out_last, 1'b0);
      chk("t6_data", out_data, '0);
      chk("t6_busy", busy, 1'b0);
      chk("t6_frames", frame_cnt, '0);
      for (int k = 0; k < NW; k++) bank[k] = WW'($urandom);
      apply_bank();
      acc_q.delete();
      step(1'b0, 1'b0, 1'b1, 1'b1);
      repeat (16) step(1'b0, 1'b0, 1'b0, 1'b1);
      sum = 0;
      for (int k = 0; k < NW; k++) sum += int'(bank[k]);
      chk("t6_len", acc_q.size(), 12);
      if (acc_q.size() == 12) begin
         for (int k = 0; k < NW; k++) chk("t6_word", acc_q[k+1], bank[k]);
         chk("t6_csum", acc_q[11], sum % 1024);
      end
      chk("t6_frames2", frame_cnt, 16'd1);

      // Random traffic; bank churns every cycle to exercise snapshot atomicity
      repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3000; i++) begin
         for (int k = 0; k < NW; k++) words_in[k*WW +: WW] = WW'($urandom);
         step(1'b0, ($urandom % 8) != 0, ($urandom % 16) == 0, ($urandom % 4) != 0);
      end
      repeat (40) step(1'b0, 1'b0, 1'b0, 1'b1);
      check_outputs();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
